// File: rtl/network_switch_arbiter.sv
// Round-robin packet arbiter: grants one requesting port at a time for a whole packet
// (or up to MAX_BEATS beats) and forwards accepted beats through a one-entry output register.
module network_switch_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             R,
    input  logic [N_PORTS-1:0][DATA_W-1:0] D,
    input  logic [N_PORTS-1:0]             L,
    output logic [N_PORTS-1:0]             in_ready,
    output logic [DATA_W-1:0]              out,
    output logic                           out_valid,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic [N_PORTS-1:0]             grant,
    output logic                           err
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   beat_cnt;

    logic [CW-1:0]   cnt_inc;
    logic            at_limit;
    logic            accept;
    logic            release_now;
    logic [PW-1:0]   owner_next;
    logic            req_found;
    logic [PW-1:0]   req_sel;
    logic [PW-1:0]   cand;

    assign cnt_inc     = beat_cnt + CW'(1);
    assign at_limit    = (cnt_inc == CW'(MAX_BEATS));
    assign accept      = (state == XFER) && R[owner] && in_ready[owner];
    assign release_now = accept && (L[owner] || at_limit);
    assign owner_next  = (owner == PW'(N_PORTS - 1)) ? '0 : owner + PW'(1);

    // in_ready follows out_ready combinationally so a drained output register refills in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        in_ready = '0;
        if (state == XFER)
            in_ready[owner] = !out_valid || out_ready;
    end

    // Scan ptr, ptr+1, ... and take the first requester; the search is only used in IDLE.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        cand      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = PW'((int'(ptr) + i) % N_PORTS);
            if (!req_found && R[cand]) begin
                req_found = 1'b1;
                req_sel   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_found) begin
                        state    <= XFER;
                        owner    <= req_sel;
                        grant    <= N_PORTS'(1) << req_sel;
                        beat_cnt <= '0;
                    end
                end
                XFER: begin
                    if (accept) begin
                        beat_cnt <= cnt_inc;
                        if (release_now) begin
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= owner_next;
                            // Forced release: the rest of the packet re-arbitrates as a new packet.
                            err   <= at_limit && !L[owner];
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                out       <= D[owner];
                out_last  <= L[owner] || at_limit;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/network_switch_arbiter.md
# network_switch_arbiter

Round-robin packet arbiter that shares the single 32-bit output of the 4-port network switch between its requesters. Each port presents multi-beat packets with a valid/ready/last handshake. The block grants one port at a time and holds the grant until that port's last beat, or until a length limit forces release. Accepted beats pass through a one-entry registered output stage toward the downstream sink.

## Interface
- N_PORTS, 4, number of requesting ports; grant and pointer arithmetic are modulo N_PORTS.
- DATA_W, 32, data width per port.
- MAX_BEATS, 16, maximum beats per packet before a forced release; beat counter is $clog2(MAX_BEATS+1) bits.

- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- R  input  N_PORTS  per-port request (valid); must hold with data until accepted.
- D  input  N_PORTS x DATA_W  per-port data beat.
- L  input  N_PORTS  per-port last-beat flag, qualified by R.
- in_ready  output  N_PORTS  per-port accept; at most one bit high.
- out  output  DATA_W  registered output data.
- out_valid  output  1  out holds a valid beat.
- out_last  output  1  beat on out is a packet's last.
- out_ready  input  1  downstream accept.
- grant  output  N_PORTS  one-hot current owner; 0 when idle.
- err  output  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, XFER.
- IDLE: grant = 0 and in_ready = 0. If any R bit is set, select the first set bit scanning ptr, ptr+1, ... (mod N_PORTS). Register grant to that one-hot value, clear beat_cnt, and go to XFER. If no R bit is set, stay in IDLE.
- XFER, with owner g: in_ready[g] = !out_valid || out_ready, which is combinational on out_ready. All other in_ready bits are 0.
- Beat accepted when R[g] && in_ready[g]. On acceptance: out <= D[g], out_last <= L[g] || (beat_cnt+1 == MAX_BEATS), out_valid <= 1, beat_cnt increments.
- Release on an accepted beat when L[g] = 1, or when beat_cnt+1 == MAX_BEATS. On release: ptr <= (g+1) mod N_PORTS, grant <= 0, state goes to IDLE.
- Forced release (limit reached and L[g] = 0): err pulses high for one cycle together with the release. The port's remaining beats are treated as a new packet at its next grant.
- Output stage: if out_valid && out_ready and no new beat is accepted, out_valid <= 0. out and out_last keep their last value when out_valid = 0.
- Requests from non-owners are ignored during XFER, with no preemption. R[g] dropping mid-packet leaves the grant in place, with no timeout.
- Reset values: state = IDLE, ptr = 0, grant = 0, in_ready = 0, out = 0, out_valid = 0, out_last = 0, err = 0, beat_cnt = 0.
- Reset mid-packet: all state returns to reset values on the next edge. A beat already in the output register is discarded, and out_valid = 0 after the edge.

## Timing
- Request sampled in IDLE at edge t: grant is valid after t. The first beat can be accepted in cycle t+1, and out_valid rises after edge t+1. Request-to-output latency is 2 cycles.
- Throughput is 1 beat/cycle within a packet while out_ready = 1.
- There is one idle (arbitration) cycle between packets. Back-to-back packets from different ports are therefore separated by one bubble cycle at the input.
- out_ready low with out_valid high: in_ready[g] = 0, and out, out_last and out_valid hold stable until out_ready is high.
- Simultaneous release and new requests: the new requests are arbitrated in the following IDLE cycle using the updated ptr.

## Test plan
- Single request: R = 0100, 3-beat packet 0xCCCC0001..0xCCCC0003 with L on beat 3, out_ready = 1. Required: grant = 0100 one cycle after R; out shows the 3 values on consecutive cycles starting 2 cycles after R; out_last only with 0xCCCC0003; ptr becomes 3.
- Contention: R = 1111 after reset, 1-beat packets D[i] = 0xi0000000. Required grant order 0001, 0010, 0100, 1000, then back to 0001, with one IDLE cycle between grants.
- Fairness: after port 1 is served, R = 0011 with both held. Required next grant is 0001 (the scan from ptr = 2 wraps around), then 0010.
- Backpressure: mid-packet, hold out_ready = 0 for 3 cycles. Required: out and out_valid stable, in_ready = 0 during the stall, no beat lost or duplicated, order preserved after release.
- Length limit: port 3 sends 20 beats with L = 0, MAX_BEATS = 16. Required: beat 16 appears with out_last = 1, err pulses once, grant drops to 0; beats 17-20 are delivered under a new grant.
- Reset mid-packet: assert rst during beat 2 of a 4-beat packet. Required: next cycle out_valid = 0, grant = 0, in_ready = 0, ptr = 0; after rst is released, R = 0001 is granted normally.
